// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the P5 MIPS datapath: sequences each instruction
// and drives the datapath write enables and mux selects, counting retired instructions.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   FETCH  | write IR from memory, PC <= PC+4
//   DECODE | capture opcode/funct, pick the instruction path
//   EXEC   | ALU operation (R-type, ori, lui, lw/sw address)
//   MEM_RD | hold lw address while data memory reads
//   MEM_WR | store word to data memory
//   WB     | write result into the register file
//   BRANCH | beq compare, PC <= branch target when equal
//   JUMP   | jal / jr PC update (jal also links $31)
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_we,
   output logic             ir_we,
   output logic             reg_we,
   output logic             mem_we,
   output logic [2:0]       alu_op,
   output logic             alu_b_sel,
   output logic             ext_op,
   output logic [1:0]       reg_dst_sel,
   output logic [2:0]       wd_sel,
   output logic [2:0]       npc_sel,
   output logic [2:0]       state,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM_RD = 3'd3,
      MEM_WR = 3'd4,
      WB     = 3'd5,
      BRANCH = 3'd6,
      JUMP   = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL
   } cls_t;

   typedef struct packed {
      logic       pc_we;
      logic       ir_we;
      logic       reg_we;
      logic       mem_we;
      logic [2:0] alu_op;
      logic       alu_b_sel;
      logic       ext_op;
      logic [1:0] reg_dst_sel;
      logic [2:0] wd_sel;
      logic [2:0] npc_sel;
      logic       instr_done;
   } ctl_t;

   function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
      cls_t c;
      c = C_NOP;
      case (op)
         6'b000000: begin
            case (fn)
               6'b100001: c = C_ADDU;
               6'b100011: c = C_SUBU;
               6'b001000: c = C_JR;
               default:   c = C_NOP;
            endcase
         end
         6'b001101: c = C_ORI;
         6'b001111: c = C_LUI;
         6'b100011: c = C_LW;
         6'b101011: c = C_SW;
         6'b000100: c = C_BEQ;
         6'b000011: c = C_JAL;
         default:   c = C_NOP;
      endcase
      return c;
   endfunction

   function automatic state_t next_of(input state_t s, input cls_t c);
      state_t n;
      n = FETCH;
      case (s)
         FETCH:  n = DECODE;
         DECODE: begin
            case (c)
               C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW: n = EXEC;
               C_BEQ:                                    n = BRANCH;
               C_JAL, C_JR:                              n = JUMP;
               default:                                  n = FETCH;
            endcase
         end
         EXEC: begin
            if (c == C_LW)      n = MEM_RD;
            else if (c == C_SW) n = MEM_WR;
            else                n = WB;
         end
         MEM_RD:  n = WB;
         default: n = FETCH;
      endcase
      return n;
   endfunction

   // Control word for a state/class pair. BRANCH pc_we and the DECODE-stage
   // NOP completion depend on live inputs and are added outside this table.
   function automatic ctl_t ctl_for(input state_t s, input cls_t c);
      ctl_t o;
      ctl_t alu;
      o   = '0;
      alu = '0;
      case (c)
         C_ADDU: begin alu.alu_op = 3'b000; alu.alu_b_sel = 1'b0; end
         C_SUBU: begin alu.alu_op = 3'b001; alu.alu_b_sel = 1'b0; end
         C_ORI:  begin alu.alu_op = 3'b010; alu.alu_b_sel = 1'b1; alu.ext_op = 1'b0; end
         C_LW, C_SW: begin
            alu.alu_op    = 3'b000;
            alu.alu_b_sel = 1'b1;
            alu.ext_op    = 1'b1;
         end
         default: alu = '0;
      endcase
      case (s)
         FETCH: begin
            o.ir_we   = 1'b1;
            o.pc_we   = 1'b1;
            o.npc_sel = 3'b000;
         end
         EXEC, MEM_RD: o = alu;
         MEM_WR: begin
            o            = alu;
            o.mem_we     = 1'b1;
            o.instr_done = 1'b1;
         end
         WB: begin
            o.reg_we     = 1'b1;
            o.instr_done = 1'b1;
            case (c)
               C_ADDU, C_SUBU: begin o.reg_dst_sel = 2'b01; o.wd_sel = 3'b000; end
               C_ORI:          begin o.reg_dst_sel = 2'b00; o.wd_sel = 3'b000; end
               C_LUI:          begin o.reg_dst_sel = 2'b00; o.wd_sel = 3'b011; end
               C_LW:           begin o.reg_dst_sel = 2'b00; o.wd_sel = 3'b001; end
               default:        begin o.reg_dst_sel = 2'b00; o.wd_sel = 3'b000; end
            endcase
         end
         BRANCH: begin
            o.alu_op     = 3'b001;
            o.alu_b_sel  = 1'b0;
            o.npc_sel    = 3'b001;
            o.instr_done = 1'b1;
         end
         JUMP: begin
            o.instr_done = 1'b1;
            if (c == C_JAL) begin
               o.pc_we       = 1'b1;
               o.npc_sel     = 3'b010;
               o.reg_we      = 1'b1;
               o.reg_dst_sel = 2'b10;
               o.wd_sel      = 3'b010;
            end else if (c == C_JR) begin
               o.pc_we   = 1'b1;
               o.npc_sel = 3'b011;
            end
         end
         default: o = '0;
      endcase
      return o;
   endfunction

   state_t     st_q;
   state_t     st_nxt;
   logic [5:0] op_q;
   logic [5:0] funct_q;
   cls_t       cls_live;
   cls_t       cls_cur;
   ctl_t       ctl_q;
   ctl_t       ctl_o;
   logic       done_now;

   assign cls_live = classify(opcode, funct);
   // DECODE steers on the live IR fields; every later state uses the captured copy.
   assign cls_cur  = (st_q == DECODE) ? cls_live : classify(op_q, funct_q);
   assign st_nxt   = next_of(st_q, cls_cur);
   assign done_now = ~reset & (ctl_q.instr_done | ((st_q == DECODE) & (cls_live == C_NOP)));

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q      <= FETCH;
         op_q      <= '0;
         funct_q   <= '0;
         ctl_q     <= ctl_for(FETCH, C_NOP);
         instr_cnt <= '0;
      end else begin
         st_q  <= st_nxt;
         ctl_q <= ctl_for(st_nxt, cls_cur);
         if (st_q == DECODE) begin
            op_q    <= opcode;
            funct_q <= funct;
         end
         if (done_now) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      ctl_o = reset ? '0 : ctl_q;
      ctl_o.pc_we      = ~reset & (ctl_q.pc_we | ((st_q == BRANCH) & zero));
      ctl_o.instr_done = done_now;
   end

   assign pc_we       = ctl_o.pc_we;
   assign ir_we       = ctl_o.ir_we;
   assign reg_we      = ctl_o.reg_we;
   assign mem_we      = ctl_o.mem_we;
   assign alu_op      = ctl_o.alu_op;
   assign alu_b_sel   = ctl_o.alu_b_sel;
   assign ext_op      = ctl_o.ext_op;
   assign reg_dst_sel = ctl_o.reg_dst_sel;
   assign wd_sel      = ctl_o.wd_sel;
   assign npc_sel     = ctl_o.npc_sel;
   assign instr_done  = ctl_o.instr_done;
   assign state       = st_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected cycle sequences are
// built from the instruction rules and compared cycle by cycle, plus counter checks.
module tb_mc_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [5:0]       opcode = '0;
   logic [5:0]       funct = '0;
   logic             zero = 1'b0;
   logic             pc_we, ir_we, reg_we, mem_we;
   logic [2:0]       alu_op;
   logic             alu_b_sel, ext_op;
   logic [1:0]       reg_dst_sel;
   logic [2:0]       wd_sel, npc_sel, state;
   logic             instr_done;
   logic [CNT_W-1:0] instr_cnt;

   mc_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_we(mem_we),
      .alu_op(alu_op), .alu_b_sel(alu_b_sel), .ext_op(ext_op),
      .reg_dst_sel(reg_dst_sel), .wd_sel(wd_sel), .npc_sel(npc_sel),
      .state(state), .instr_done(instr_done), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       pc_we, ir_we, reg_we, mem_we;
      logic [2:0] alu_op;
      logic       b_sel, ext;
      logic [1:0] dst;
      logic [2:0] wd, npc;
      logic       done;
   } cyc_t;

   cyc_t obs;
   assign obs = {state, pc_we, ir_we, reg_we, mem_we, alu_op, alu_b_sel, ext_op,
                 reg_dst_sel, wd_sel, npc_sel, instr_done};

   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;
   cyc_t exp_q[$];

   function automatic string kind(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00) begin
         if (fn == 6'h21) return "addu";
         if (fn == 6'h23) return "subu";
         if (fn == 6'h08) return "jr";
         return "nop";
      end
      if (op == 6'h0D) return "ori";
      if (op == 6'h0F) return "lui";
      if (op == 6'h23) return "lw";
      if (op == 6'h2B) return "sw";
      if (op == 6'h04) return "beq";
      if (op == 6'h03) return "jal";
      return "nop";
   endfunction

   // Expected per-cycle behaviour of one instruction, written from the ISA rules.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
      cyc_t  c;
      string k;
      k = kind(op, fn);
      exp_q.delete();
      c = '0; c.st = 3'd0; c.pc_we = 1; c.ir_we = 1; exp_q.push_back(c);
      c = '0; c.st = 3'd1; c.done = (k == "nop"); exp_q.push_back(c);
      if (k == "addu" || k == "subu") begin
         c = '0; c.st = 3'd2; c.alu_op = (k == "subu") ? 3'd1 : 3'd0; exp_q.push_back(c);
         c = '0; c.st = 3'd5; c.reg_we = 1; c.dst = 2'b01; c.wd = 3'd0; c.done = 1; exp_q.push_back(c);
      end else if (k == "ori") begin
         c = '0; c.st = 3'd2; c.alu_op = 3'd2; c.b_sel = 1; exp_q.push_back(c);
         c = '0; c.st = 3'd5; c.reg_we = 1; c.done = 1; exp_q.push_back(c);
      end else if (k == "lui") begin
         c = '0; c.st = 3'd2; exp_q.push_back(c);
         c = '0; c.st = 3'd5; c.reg_we = 1; c.wd = 3'd3; c.done = 1; exp_q.push_back(c);
      end else if (k == "lw") begin
         c = '0; c.st = 3'd2; c.b_sel = 1; c.ext = 1; exp_q.push_back(c);
         c.st = 3'd3; exp_q.push_back(c);
         c = '0; c.st = 3'd5; c.reg_we = 1; c.wd = 3'd1; c.done = 1; exp_q.push_back(c);
      end else if (k == "sw") begin
         c = '0; c.st = 3'd2; c.b_sel = 1; c.ext = 1; exp_q.push_back(c);
         c.st = 3'd4; c.mem_we = 1; c.done = 1; exp_q.push_back(c);
      end else if (k == "beq") begin
         c = '0; c.st = 3'd6; c.alu_op = 3'd1; c.npc = 3'd1; c.pc_we = z; c.done = 1; exp_q.push_back(c);
      end else if (k == "jal") begin
         c = '0; c.st = 3'd7; c.pc_we = 1; c.npc = 3'd2; c.reg_we = 1; c.dst = 2'b10;
         c.wd = 3'd2; c.done = 1; exp_q.push_back(c);
      end else if (k == "jr") begin
         c = '0; c.st = 3'd7; c.pc_we = 1; c.npc = 3'd3; c.done = 1; exp_q.push_back(c);
      end
   endtask

   // Entered #1 after the edge that starts FETCH; leaves #1 after the next FETCH edge.
   // stop_at >= 0 ends the instruction early (before that cycle index).
   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int stop_at);
      int n;
      build(op, fn, z);
      n = exp_q.size();
      if (stop_at >= 0 && stop_at < n) n = stop_at;
      for (int i = 0; i < n; i++) begin
         if (i == 1) begin
            opcode = op;
            funct  = fn;
         end else begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
         end
         zero = (exp_q[i].st == 3'd6) ? z : 1'($urandom);
         @(negedge clk);
         checks++;
         if (obs !== exp_q[i]) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, i, obs, exp_q[i]);
         end
         if (exp_q[i].done) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
         @(posedge clk); #1;
      end
      if (stop_at < 0) begin
         checks++;
         if (instr_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL %s instr_cnt got %0d expected %0d", name, instr_cnt, exp_cnt);
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (obs !== cyc_t'(0)) begin
         errors++;
         $display("FAIL reset_outputs got %h expected %h", obs, cyc_t'(0));
      end
      checks++;
      if (instr_cnt !== '0) begin
         errors++;
         $display("FAIL reset_cnt got %0d expected 0", instr_cnt);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic test_reset_mid();
      cyc_t e;
      run_instr("reset_mid_pre", 6'h00, 6'h21, 1'b0, 2);
      reset = 1'b1;
      @(negedge clk);
      e = '0; e.st = 3'd2;
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset_mid_exec got %h expected %h", obs, e);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (obs !== cyc_t'(0)) begin
         errors++;
         $display("FAIL reset_mid_fetch got %h expected %h", obs, cyc_t'(0));
      end
      @(posedge clk); #1;
      reset = 1'b0;
      exp_cnt = 0;
      checks++;
      if (instr_cnt !== '0) begin
         errors++;
         $display("FAIL reset_mid_cnt got %0d expected 0", instr_cnt);
      end
      run_instr("reset_mid_post_addu", 6'h00, 6'h21, 1'b0, -1);
   endtask

   task automatic test_addu();
      run_instr("addu", 6'h00, 6'h21, 1'b0, -1);
      run_instr("subu", 6'h00, 6'h23, 1'b1, -1);
   endtask

   task automatic test_lw_sw();
      run_instr("lw", 6'h23, 6'($urandom), 1'b0, -1);
      run_instr("sw", 6'h2B, 6'($urandom), 1'b1, -1);
      run_instr("ori", 6'h0D, 6'($urandom), 1'b0, -1);
      run_instr("lui", 6'h0F, 6'($urandom), 1'b1, -1);
   endtask

   task automatic test_beq();
      run_instr("beq_taken", 6'h04, 6'($urandom), 1'b1, -1);
      run_instr("beq_not_taken", 6'h04, 6'($urandom), 1'b0, -1);
   endtask

   task automatic test_jump();
      run_instr("jal", 6'h03, 6'($urandom), 1'b0, -1);
      run_instr("jr", 6'h00, 6'h08, 1'b1, -1);
   endtask

   task automatic test_nop_wrap();
      run_instr("undef_3f", 6'h3F, 6'h21, 1'b0, -1);
      run_instr("nop_zero", 6'h00, 6'h00, 1'b0, -1);
      do_reset();
      for (int i = 0; i < 16; i++)
         run_instr("nop_wrap", (i % 2 == 0) ? 6'h00 : 6'h3F, 6'h00, 1'b0, -1);
      checks++;
      if (instr_cnt !== '0) begin
         errors++;
         $display("FAIL nop_wrap_final got %0d expected 0", instr_cnt);
      end
   endtask

   task automatic test_random();
      logic [5:0] op, fn;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 10))
            0: begin op = 6'h00; fn = 6'h21; end
            1: begin op = 6'h00; fn = 6'h23; end
            2: begin op = 6'h00; fn = 6'h08; end
            3: begin op = 6'h0D; fn = 6'($urandom); end
            4: begin op = 6'h0F; fn = 6'($urandom); end
            5: begin op = 6'h23; fn = 6'($urandom); end
            6: begin op = 6'h2B; fn = 6'($urandom); end
            7: begin op = 6'h04; fn = 6'($urandom); end
            8: begin op = 6'h03; fn = 6'($urandom); end
            9: begin op = 6'h00; fn = 6'($urandom); end
            default: begin op = 6'($urandom); fn = 6'($urandom); end
         endcase
         run_instr("random", op, fn, 1'($urandom), -1);
      end
   endtask

   task automatic test_back_to_back();
      run_instr("b2b_lw", 6'h23, 6'h00, 1'b0, -1);
      run_instr("b2b_beq", 6'h04, 6'h00, 1'b1, -1);
      run_instr("b2b_nop", 6'h00, 6'h00, 1'b0, -1);
      run_instr("b2b_jal", 6'h03, 6'h00, 1'b0, -1);
      run_instr("b2b_sw", 6'h2B, 6'h00, 1'b0, -1);
   endtask

   initial begin
      reset = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_addu();
      test_reset_mid();
      test_lw_sw();
      test_beq();
      test_jump();
      test_nop_wrap();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
